// File: rtl/alu_ctrl_md.sv
// EX-stage ALU control: opcode/funct decode plus background sequencing of an
// external iterative mul/div unit, stalling only on HI/LO hazards.
module alu_ctrl_md #(
   parameter int unsigned CONF_W     = 4,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32,
   parameter bit          ENABLE_MD  = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [2:0]        i_aluop,
   input  logic [5:0]        i_funct,
   output logic [CONF_W-1:0] o_aluconf,
   output logic              o_sign,
   output logic              o_md_start,
   output logic [1:0]        o_md_op,
   output logic              o_md_busy,
   output logic              o_md_done,
   output logic [1:0]        o_hilo_sel,
   output logic              o_stall
);

   localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   typedef enum logic [3:0] {
      C_AND = 4'd0, C_OR  = 4'd1, C_ADD = 4'd2, C_SUB = 4'd3, C_SLT = 4'd4,
      C_NOR = 4'd5, C_XOR = 4'd6, C_SLL = 4'd7, C_SRL = 4'd8, C_SRA = 4'd9
   } conf_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   conf_e            conf;
   logic             is_r, md_funct, hilo_funct, md_req, hilo_rd, not_idle;

   always_comb begin
      conf = C_ADD;
      unique case (i_aluop)
         3'b000:  conf = C_ADD;
         3'b001:  conf = C_SUB;
         3'b011:  conf = C_AND;
         3'b100:  conf = C_SLT;
         3'b010: begin
            case (i_funct)
               6'h20, 6'h21: conf = C_ADD;
               6'h22, 6'h23: conf = C_SUB;
               6'h24:        conf = C_AND;
               6'h25:        conf = C_OR;
               6'h26:        conf = C_XOR;
               6'h27:        conf = C_NOR;
               6'h2a, 6'h2b: conf = C_SLT;
               6'h00:        conf = C_SLL;
               6'h02:        conf = C_SRL;
               6'h03:        conf = C_SRA;
               default:      conf = C_ADD;
            endcase
         end
         default: conf = C_ADD;
      endcase
   end

   assign is_r       = (i_aluop == 3'b010);
   assign md_funct   = (i_funct[5:2] == 4'b0110);
   assign hilo_funct = (i_funct == 6'h10) || (i_funct == 6'h12);

   assign o_aluconf = CONF_W'(conf);
   assign o_sign    = !(is_r && ((i_funct == 6'h21) || (i_funct == 6'h23) || (i_funct == 6'h2b) ||
                                 (i_funct == 6'h19) || (i_funct == 6'h1b)));

   always_comb begin
      o_hilo_sel = 2'b00;
      if (ENABLE_MD && is_r && (i_funct == 6'h10)) o_hilo_sel = 2'b01;
      if (ENABLE_MD && is_r && (i_funct == 6'h12)) o_hilo_sel = 2'b10;
   end

   assign md_req   = i_valid && is_r && md_funct && ENABLE_MD;
   assign hilo_rd  = i_valid && is_r && hilo_funct && ENABLE_MD;
   assign not_idle = (state_q != S_IDLE);

   // Gated by reset so the handshake outputs read idle for the whole reset cycle.
   assign o_md_start = md_req && !not_idle && !i_rst;
   assign o_md_op    = i_funct[1:0];
   assign o_stall    = (md_req || hilo_rd) && not_idle && !i_rst;
   assign o_md_busy  = not_idle && !i_rst;
   assign o_md_done  = (state_q == S_DONE) && !i_rst;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (o_md_start) begin
               state_d = i_funct[1] ? S_DIV : S_MUL;
               cnt_d   = i_funct[1] ? DIV_LOAD : MUL_LOAD;
            end
         end
         S_MUL, S_DIV: begin
            if (cnt_q == '0) state_d = S_DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: expectations are queued as each step is
// driven and drained against the DUT outputs mid-cycle.
module tb_alu_ctrl_md;

   logic       clk = 1'b0;
   logic       rst, valid;
   logic [2:0] aluop;
   logic [5:0] funct;

   logic [3:0] conf,  conf0;
   logic       sign,  sign0;
   logic       start, start0;
   logic [1:0] op,    op0;
   logic       busy,  busy0;
   logic       done,  done0;
   logic [1:0] sel,   sel0;
   logic       stall, stall0;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   alu_ctrl_md #(.CONF_W(4), .MUL_CYCLES(4), .DIV_CYCLES(32), .ENABLE_MD(1'b1)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_aluop(aluop), .i_funct(funct),
      .o_aluconf(conf), .o_sign(sign), .o_md_start(start), .o_md_op(op),
      .o_md_busy(busy), .o_md_done(done), .o_hilo_sel(sel), .o_stall(stall)
   );

   alu_ctrl_md #(.CONF_W(4), .MUL_CYCLES(4), .DIV_CYCLES(32), .ENABLE_MD(1'b0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_aluop(aluop), .i_funct(funct),
      .o_aluconf(conf0), .o_sign(sign0), .o_md_start(start0), .o_md_op(op0),
      .o_md_busy(busy0), .o_md_done(done0), .o_hilo_sel(sel0), .o_stall(stall0)
   );

   localparam int unsigned F_CONF = 0, F_SIGN = 1, F_START = 2, F_OP = 3, F_BUSY = 4,
                           F_DONE = 5, F_SEL = 6, F_STALL = 7, F_CONF0 = 8, F_START0 = 9,
                           F_STALL0 = 10, F_BUSY0 = 11;

   typedef struct {
      string       tag;
      int unsigned fld;
      logic [7:0]  val;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic [2:0] aop;
      logic [5:0] fn;
      logic [7:0] cf;
      logic [7:0] sg;
      logic [7:0] hs;
   } dec_t;

   dec_t dec_tab[$];

   function automatic logic [7:0] observe(int unsigned fld);
      case (fld)
         F_CONF:   return {4'b0, conf};
         F_SIGN:   return {7'b0, sign};
         F_START:  return {7'b0, start};
         F_OP:     return {6'b0, op};
         F_BUSY:   return {7'b0, busy};
         F_DONE:   return {7'b0, done};
         F_SEL:    return {6'b0, sel};
         F_STALL:  return {7'b0, stall};
         F_CONF0:  return {4'b0, conf0};
         F_START0: return {7'b0, start0};
         F_STALL0: return {7'b0, stall0};
         F_BUSY0:  return {7'b0, busy0};
         default:  return 8'hxx;
      endcase
   endfunction

   task automatic expect_val(input string tag, input int unsigned fld, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.fld = fld;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic drive(input logic r, input logic v, input logic [2:0] a, input logic [5:0] f);
      @(negedge clk);
      rst   = r;
      valid = v;
      aluop = a;
      funct = f;
   endtask

   task automatic check_all();
      exp_t       e;
      logic [7:0] obs;
      #2;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.fld);
         vectors++;
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic add_dec(input logic [2:0] a, input logic [5:0] f, input logic [7:0] c,
                          input logic [7:0] s, input logic [7:0] h);
      dec_t d;
      d.aop = a; d.fn = f; d.cf = c; d.sg = s; d.hs = h;
      dec_tab.push_back(d);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; aluop = '0; funct = '0;

      drive(1'b1, 1'b0, 3'b000, 6'h00);
      expect_val("rst_busy", F_BUSY, 8'd0);
      expect_val("rst_done", F_DONE, 8'd0);
      expect_val("rst_start", F_START, 8'd0);
      expect_val("rst_stall", F_STALL, 8'd0);
      check_all();
      drive(1'b1, 1'b1, 3'b010, 6'h18);
      expect_val("rst_mult_start", F_START, 8'd0);
      expect_val("rst_mult_conf", F_CONF, 8'd2);
      expect_val("rst_mult_busy", F_BUSY, 8'd0);
      check_all();

      add_dec(3'b010, 6'h21, 2, 0, 0); add_dec(3'b010, 6'h2a, 4, 1, 0);
      add_dec(3'b010, 6'h3f, 2, 1, 0); add_dec(3'b011, 6'h00, 0, 1, 0);
      add_dec(3'b111, 6'h00, 2, 1, 0); add_dec(3'b000, 6'h22, 2, 1, 0);
      add_dec(3'b001, 6'h00, 3, 1, 0); add_dec(3'b100, 6'h00, 4, 1, 0);
      add_dec(3'b010, 6'h20, 2, 1, 0); add_dec(3'b010, 6'h22, 3, 1, 0);
      add_dec(3'b010, 6'h23, 3, 0, 0); add_dec(3'b010, 6'h24, 0, 1, 0);
      add_dec(3'b010, 6'h25, 1, 1, 0); add_dec(3'b010, 6'h26, 6, 1, 0);
      add_dec(3'b010, 6'h27, 5, 1, 0); add_dec(3'b010, 6'h2b, 4, 0, 0);
      add_dec(3'b010, 6'h00, 7, 1, 0); add_dec(3'b010, 6'h02, 8, 1, 0);
      add_dec(3'b010, 6'h03, 9, 1, 0); add_dec(3'b010, 6'h19, 2, 0, 0);
      add_dec(3'b010, 6'h1b, 2, 0, 0); add_dec(3'b010, 6'h08, 2, 1, 0);
      add_dec(3'b010, 6'h10, 2, 1, 1); add_dec(3'b010, 6'h12, 2, 1, 2);
      add_dec(3'b101, 6'h10, 2, 1, 0);
      foreach (dec_tab[i]) begin
         drive(1'b0, 1'b0, dec_tab[i].aop, dec_tab[i].fn);
         expect_val($sformatf("dec_conf[%0d]", i), F_CONF, dec_tab[i].cf);
         expect_val($sformatf("dec_sign[%0d]", i), F_SIGN, dec_tab[i].sg);
         expect_val($sformatf("dec_sel[%0d]", i), F_SEL, dec_tab[i].hs);
         expect_val($sformatf("dec_conf0[%0d]", i), F_CONF0, dec_tab[i].cf);
         check_all();
      end

      // MULT issued at T
      drive(1'b0, 1'b1, 3'b010, 6'h18);
      expect_val("mult_start", F_START, 8'd1);
      expect_val("mult_op", F_OP, 8'd0);
      expect_val("mult_busy_T", F_BUSY, 8'd0);
      expect_val("mult_stall", F_STALL, 8'd0);
      expect_val("mult_conf", F_CONF, 8'd2);
      expect_val("nomd_conf", F_CONF0, 8'd2);
      expect_val("nomd_start", F_START0, 8'd0);
      check_all();
      drive(1'b0, 1'b0, 3'b010, 6'h18);
      expect_val("mult_busy_T1", F_BUSY, 8'd1);
      expect_val("mult_done_T1", F_DONE, 8'd0);
      expect_val("flush_nostart", F_START, 8'd0);
      check_all();
      drive(1'b0, 1'b1, 3'b010, 6'h20);
      expect_val("add_busy_stall", F_STALL, 8'd0);
      expect_val("add_busy_conf", F_CONF, 8'd2);
      expect_val("add_busy_busy", F_BUSY, 8'd1);
      check_all();
      for (int unsigned k = 3; k <= 4; k++) begin
         drive(1'b0, 1'b1, 3'b010, 6'h12);
         expect_val($sformatf("mflo_stall_T%0d", k), F_STALL, 8'd1);
         expect_val($sformatf("mflo_sel_T%0d", k), F_SEL, 8'd2);
         expect_val($sformatf("mflo_done_T%0d", k), F_DONE, 8'd0);
         expect_val($sformatf("nomd_stall_T%0d", k), F_STALL0, 8'd0);
         check_all();
      end
      drive(1'b0, 1'b1, 3'b010, 6'h12);
      expect_val("mflo_stall_T5", F_STALL, 8'd1);
      expect_val("mult_done_T5", F_DONE, 8'd1);
      expect_val("mult_busy_T5", F_BUSY, 8'd1);
      check_all();
      drive(1'b0, 1'b1, 3'b010, 6'h12);
      expect_val("mflo_stall_T6", F_STALL, 8'd0);
      expect_val("mflo_sel_T6", F_SEL, 8'd2);
      expect_val("mult_busy_T6", F_BUSY, 8'd0);
      expect_val("mult_done_T6", F_DONE, 8'd0);
      expect_val("mflo_start_T6", F_START, 8'd0);
      check_all();
      drive(1'b0, 1'b0, 3'b010, 6'h1b);
      expect_val("divu_flush_start", F_START, 8'd0);
      expect_val("divu_flush_busy", F_BUSY, 8'd0);
      check_all();

      // DIVU at T, DIV presented on its DONE cycle
      drive(1'b0, 1'b1, 3'b010, 6'h1b);
      expect_val("divu_start", F_START, 8'd1);
      expect_val("divu_op", F_OP, 8'd3);
      expect_val("divu_sign", F_SIGN, 8'd0);
      check_all();
      for (int unsigned k = 1; k <= 32; k++) begin
         drive(1'b0, 1'b0, 3'b000, 6'h00);
         expect_val($sformatf("divu_busy_T%0d", k), F_BUSY, 8'd1);
         expect_val($sformatf("divu_done_T%0d", k), F_DONE, 8'd0);
         check_all();
      end
      drive(1'b0, 1'b1, 3'b010, 6'h1a);
      expect_val("div_in_done_stall", F_STALL, 8'd1);
      expect_val("div_in_done_start", F_START, 8'd0);
      expect_val("divu_done_T33", F_DONE, 8'd1);
      check_all();
      drive(1'b0, 1'b1, 3'b010, 6'h1a);
      expect_val("div_next_stall", F_STALL, 8'd0);
      expect_val("div_next_start", F_START, 8'd1);
      expect_val("div_next_op", F_OP, 8'd2);
      expect_val("div_next_busy", F_BUSY, 8'd0);
      expect_val("nomd_busy", F_BUSY0, 8'd0);
      check_all();

      // Reset three cycles into the DIV aborts it silently
      for (int unsigned k = 1; k <= 2; k++) begin
         drive(1'b0, 1'b0, 3'b000, 6'h00);
         expect_val($sformatf("div_busy_T%0d", k), F_BUSY, 8'd1);
         check_all();
      end
      drive(1'b1, 1'b1, 3'b010, 6'h1a);
      expect_val("midrst_busy", F_BUSY, 8'd0);
      expect_val("midrst_stall", F_STALL, 8'd0);
      expect_val("midrst_start", F_START, 8'd0);
      expect_val("midrst_done", F_DONE, 8'd0);
      check_all();
      for (int unsigned k = 4; k <= 40; k++) begin
         drive(1'b0, 1'b0, 3'b000, 6'h00);
         expect_val($sformatf("post_rst_busy_T%0d", k), F_BUSY, 8'd0);
         expect_val($sformatf("post_rst_done_T%0d", k), F_DONE, 8'd0);
         check_all();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
